// File: rtl/fir_filter.sv
`default_nettype none
// ============================================================================
//  Module      : fir_filter
//  Description : Four-tap signed FIR with a two-stage multiply/sum pipeline,
//                rounded and saturated to an 8-bit output with valid strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module fir_filter #(
    parameter logic signed [7:0] C0    = 8'sd16,
    parameter logic signed [7:0] C1    = 8'sd48,
    parameter logic signed [7:0] C2    = 8'sd48,
    parameter logic signed [7:0] C3    = 8'sd16,
    parameter int unsigned       SHIFT = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic signed [7:0] data,
    input  logic              dv,
    output logic signed [7:0] q,
    output logic              qv,
    output logic              sat,
    output logic              primed
);

    localparam logic signed [17:0] c_round = 18'sd1 <<< (SHIFT - 1);
    localparam logic signed [17:0] c_max   = 18'sd127;
    localparam logic signed [17:0] c_min   = -18'sd128;
    localparam logic        [2:0]  c_full  = 3'd4;

    logic signed [7:0]  r_x0, r_x1, r_x2, r_x3;
    logic signed [15:0] r_p0, r_p1, r_p2, r_p3;
    logic               r_v1, r_v2;
    logic        [2:0]  r_cnt;
    logic signed [7:0]  r_q;
    logic               r_sat, r_qv;

    logic signed [17:0] w_sum;
    logic signed [17:0] w_rnd;

    // Tap delay line and fill counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x0  <= '0;
            r_x1  <= '0;
            r_x2  <= '0;
            r_x3  <= '0;
            r_cnt <= '0;
        end else if (dv) begin
            r_x3 <= r_x2;
            r_x2 <= r_x1;
            r_x1 <= r_x0;
            r_x0 <= data;
            if (r_cnt != c_full) begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    // Stage 1: products of the already-shifted taps
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p0 <= '0;
            r_p1 <= '0;
            r_p2 <= '0;
            r_p3 <= '0;
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            r_v1 <= dv;
            r_v2 <= r_v1;
            if (r_v1) begin
                r_p0 <= C0 * r_x0;
                r_p1 <= C1 * r_x1;
                r_p2 <= C2 * r_x2;
                r_p3 <= C3 * r_x3;
            end
        end
    end

    always_comb begin
        w_sum = $signed({{2{r_p0[15]}}, r_p0}) + $signed({{2{r_p1[15]}}, r_p1})
              + $signed({{2{r_p2[15]}}, r_p2}) + $signed({{2{r_p3[15]}}, r_p3});
        w_rnd = (w_sum + c_round) >>> SHIFT;
    end

    // Stage 2: round, saturate and register the output
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= '0;
            r_sat <= 1'b0;
            r_qv  <= 1'b0;
        end else begin
            r_qv <= r_v2;
            if (r_v2) begin
                if (w_rnd > c_max) begin
                    r_q   <= 8'sd127;
                    r_sat <= 1'b1;
                end else if (w_rnd < c_min) begin
                    r_q   <= -8'sd128;
                    r_sat <= 1'b1;
                end else begin
                    r_q   <= w_rnd[7:0];
                    r_sat <= 1'b0;
                end
            end
        end
    end

    assign q      = r_q;
    assign qv     = r_qv;
    assign sat    = r_sat;
    assign primed = (r_cnt == c_full);

endmodule
`default_nettype wire

// File: tb/tb_fir_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_filter
//  Description : Scoreboard bench for fir_filter (default and all-64 taps).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fir_filter;

    localparam int c_shift = 7;

    typedef struct {
        logic [7:0] q;
        logic       sat;
        int         cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic signed [7:0] data = '0;
    logic              dv = 1'b0;
    logic signed [7:0] q_d, q_s;
    logic              qv_d, qv_s, sat_d, sat_s, primed_d, primed_s;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   mx [4] = '{0, 0, 0, 0};
    int   m_cnt = 0;
    exp_t sb_d[$];
    exp_t sb_s[$];

    fir_filter #(.SHIFT(c_shift)) dut (
        .clk(clk), .rst(rst), .data(data), .dv(dv),
        .q(q_d), .qv(qv_d), .sat(sat_d), .primed(primed_d)
    );

    fir_filter #(.C0(8'sd64), .C1(8'sd64), .C2(8'sd64), .C3(8'sd64), .SHIFT(c_shift)) dut_s (
        .clk(clk), .rst(rst), .data(data), .dv(dv),
        .q(q_s), .qv(qv_s), .sat(sat_s), .primed(primed_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     tag, act, act, exp, exp, cyc);
        end
    endtask

    function automatic exp_t model(input int c0, input int c1, input int c2, input int c3);
        exp_t e;
        int   s, r;
        s = c0 * mx[0] + c1 * mx[1] + c2 * mx[2] + c3 * mx[3];
        r = (s + (1 << (c_shift - 1))) >>> c_shift;
        if (r > 127) begin
            e.q = 8'd127;  e.sat = 1'b1;
        end else if (r < -128) begin
            e.q = 8'h80;   e.sat = 1'b1;
        end else begin
            e.q = r[7:0];  e.sat = 1'b0;
        end
        e.cyc = 0;
        return e;
    endfunction

    // One cycle of stimulus; also checks primed against the model fill count
    task automatic drive(input logic v, input logic signed [7:0] d, input logic r);
        exp_t e;
        @(posedge clk);
        #1;
        check("primed", {31'd0, primed_d}, {31'd0, m_cnt == 4});
        check("primed_s", {31'd0, primed_s}, {31'd0, m_cnt == 4});
        rst  = r;
        dv   = v;
        data = d;
        if (r) begin
            mx = '{0, 0, 0, 0};
            m_cnt = 0;
            sb_d.delete();
            sb_s.delete();
        end else if (v) begin
            mx[3] = mx[2];
            mx[2] = mx[1];
            mx[1] = mx[0];
            mx[0] = int'(d);
            if (m_cnt < 4) m_cnt++;
            e = model(16, 48, 48, 16);
            e.cyc = cyc + 3;
            sb_d.push_back(e);
            e = model(64, 64, 64, 64);
            e.cyc = cyc + 3;
            sb_s.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'sd0, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (qv_d) begin
            if (sb_d.size() == 0) begin
                check("spurious_qv", 32'd1, 32'd0);
            end else begin
                e = sb_d.pop_front();
                check("q", {24'd0, q_d}, {24'd0, e.q});
                check("sat", {31'd0, sat_d}, {31'd0, e.sat});
                check("latency", cyc, e.cyc);
            end
        end
        if (qv_s) begin
            if (sb_s.size() == 0) begin
                check("spurious_qv_s", 32'd1, 32'd0);
            end else begin
                e = sb_s.pop_front();
                check("q_s", {24'd0, q_s}, {24'd0, e.q});
                check("sat_s", {31'd0, sat_s}, {31'd0, e.sat});
                check("latency_s", cyc, e.cyc);
            end
        end
    end

    initial begin
        drive(1'b0, 8'sd0, 1'b1);
        drive(1'b0, 8'sd0, 1'b1);
        drive(1'b0, 8'sd0, 1'b0);
        check("rst_q", {24'd0, q_d}, 32'd0);
        check("rst_qv", {31'd0, qv_d}, 32'd0);
        check("rst_sat", {31'd0, sat_d}, 32'd0);
        check("rst_q_s", {24'd0, q_s}, 32'd0);

        // Impulse, back-to-back zeros
        drive(1'b1, 8'sd64, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 8'sd0, 1'b0);
        idle(5);

        // Step at reader pacing
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'sd100, 1'b0);
            idle(2);
        end
        idle(4);

        // Negative full scale, then positive/negative saturation on dut_s
        for (int i = 0; i < 4; i++) drive(1'b1, -8'sd128, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 8'sd127, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, -8'sd128, 1'b0);
        idle(5);

        // Back-to-back ramp
        for (int i = 1; i <= 6; i++) drive(1'b1, 8'(i), 1'b0);
        idle(4);

        // Random traffic
        for (int i = 0; i < 60; i++)
            drive(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
        idle(5);

        // Reset one edge after a strobe, with dv held high during reset
        drive(1'b1, 8'sd50, 1'b0);
        drive(1'b1, 8'sd77, 1'b1);
        drive(1'b0, 8'sd0, 1'b0);
        check("mid_rst_q", {24'd0, q_d}, 32'd0);
        check("mid_rst_qv", {31'd0, qv_d}, 32'd0);
        check("mid_rst_primed", {31'd0, primed_d}, 32'd0);
        idle(4);

        // Impulse again after reset
        drive(1'b1, 8'sd64, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 8'sd0, 1'b0);
        idle(8);

        check("drain", sb_d.size(), 32'd0);
        check("drain_s", sb_s.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
